// File: rtl/result_deserializer.sv
// Serial-to-parallel result collector: gathers ALU result bits LSB first into a word plus zero/carry flags.
// Latency: result_valid rises one edge after the WIDTH-th accepted bit (min WIDTH+1 edges from start).
// Backpressure: the word is held until store_ack; bits arriving while held are dropped and flag overrun.
module result_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             carry_in,
    input  logic             store_ack,
    output logic [WIDTH-1:0] result_out,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic             zero_acc;
    logic             restart;
    logic             take_bit;
    logic             last_bit;
    logic             set_ovr;

    assign shift_nxt = {bit_in, shift[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start wins over a same-cycle bit; in HOLD it only counts together with store_ack
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        take_bit  = 1'b0;
        last_bit  = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (start) begin
                    restart = 1'b1;
                end else if (bit_valid) begin
                    take_bit = 1'b1;
                    if (bit_count == CNT_W'(WIDTH - 1)) begin
                        last_bit  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (store_ack && start) begin
                    restart   = 1'b1;
                    state_nxt = CAPTURE;
                end else begin
                    set_ovr = bit_valid;
                    if (store_ack) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift        <= '0;
            bit_count    <= '0;
            zero_acc     <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            busy         <= (state_nxt == CAPTURE);
            result_valid <= (state_nxt == HOLD);
            if (restart) begin
                shift     <= '0;
                bit_count <= '0;
                zero_acc  <= 1'b1;
                overrun   <= 1'b0;
            end else if (take_bit) begin
                shift    <= shift_nxt;
                zero_acc <= zero_acc & ~bit_in;
                if (last_bit) begin
                    bit_count  <= '0;
                    result_out <= shift_nxt;
                    zero_flag  <= zero_acc & ~bit_in;
                    carry_flag <= carry_in;
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end else if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
